// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : counter_pkg
// Description : Shared constants and helpers for the up/down counter family.
//               DIR_UP / DIR_DN name the two levels of the up_dn input.
//               clog2 lets instantiators size WIDTH from a MODULUS.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Number of bits needed to hold the values 0..value-1. Never returns less
    // than 1, so a modulus of 1 or 2 still yields a usable one-bit counter.
    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int              bits;
        v    = (value > 64'd1) ? value - 64'd1 : 64'd0;
        bits = 0;
        for (int i = 0; i < 64; i++) begin
            if ((v >> i) != 64'd0) begin
                bits = i + 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/mod_step.sv
`default_nettype none
// ============================================================================
// Module      : mod_step
// Description : Purely combinational modulo-N step. Given the current count
//               and direction it produces the next count and a flag that is
//               set when the step wraps around the ends of the range.
// Ports       : q         in  WIDTH  current count
//               up_dn     in  1      1 = count up, 0 = count down
//               next_q    out WIDTH  count after one step
//               wrap_next out 1      step wraps (MODULUS-1 -> 0 or 0 -> MODULUS-1)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_step
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap_next
);

    // Terminal value held one bit wider than the count so that a full-range
    // modulus (2**WIDTH) is representable without truncation.
    localparam longint         C_MAX_L = MODULUS - 64'sd1;
    localparam logic [WIDTH:0] C_MAX   = C_MAX_L[WIDTH:0];

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_next_ext;
    logic           w_unused_msb;

    assign w_q_ext = {1'b0, q};

    always_comb begin
        w_next_ext = w_q_ext;
        wrap_next  = 1'b0;
        if (up_dn == DIR_UP) begin
            if (w_q_ext == C_MAX) begin
                w_next_ext = '0;
                wrap_next  = 1'b1;
            end else begin
                w_next_ext = w_q_ext + 1'b1;
            end
        end else begin
            if (w_q_ext == '0) begin
                w_next_ext = C_MAX;
                wrap_next  = 1'b1;
            end else begin
                w_next_ext = w_q_ext - 1'b1;
            end
        end
    end

    // The explicit wrap branches keep the result inside 0..MODULUS-1, so the
    // extra top bit is always zero here.
    assign next_q       = w_next_ext[WIDTH-1:0];
    assign w_unused_msb = w_next_ext[WIDTH];

endmodule : mod_step
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_updown_counter
// Description : Synchronous modulo-N up/down counter with enable, synchronous
//               clear, parallel load with range clamping, a combinational
//               terminal count for cascading and registered wrap / load-error
//               pulses.
// Ports       : clk       in  1      rising-edge clock
//               reset     in  1      asynchronous active-high reset
//               en        in  1      count enable
//               up_dn     in  1      1 = up, 0 = down
//               clear     in  1      synchronous clear to 0 (highest priority)
//               load      in  1      synchronous parallel load
//               load_val  in  WIDTH  value to load
//               q         out WIDTH  current count
//               tc        out 1      terminal count (combinational)
//               wrap      out 1      one-cycle pulse after a counting wrap
//               load_err  out 1      one-cycle pulse after an out-of-range load
// Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = 16,
    parameter longint RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("mod_updown_counter: WIDTH must be in 1..32");
        end
        if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
            $error("mod_updown_counter: RESET_VAL must be below MODULUS");
        end
    endgenerate

    localparam longint           C_MAX_L   = MODULUS - 64'sd1;
    localparam logic [WIDTH:0]   C_MAX     = C_MAX_L[WIDTH:0];
    localparam longint           C_RESET_L = RESET_VAL;
    localparam logic [WIDTH-1:0] C_RESET   = C_RESET_L[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_load_err;

    logic [WIDTH-1:0] w_step_q;
    logic             w_step_wrap;
    logic             w_load_oor;
    logic             w_at_max;
    logic             w_at_zero;

    mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q         (r_q),
        .up_dn     (up_dn),
        .next_q    (w_step_q),
        .wrap_next (w_step_wrap)
    );

    // Range checks are done one bit wider so MODULUS == 2**WIDTH never
    // flags a load as out of range.
    assign w_load_oor = ({1'b0, load_val} > C_MAX);
    assign w_at_max   = ({1'b0, r_q} == C_MAX);
    assign w_at_zero  = (r_q == '0);

    // Terminal count is only meaningful when the next edge will actually
    // count, so clear and load suppress it.
    assign tc = en & ~clear & ~load & ((up_dn == DIR_UP) ? w_at_max : w_at_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q        <= C_RESET;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (clear) begin
                r_q <= '0;
            end else if (load) begin
                if (w_load_oor) begin
                    r_q        <= C_MAX[WIDTH-1:0];
                    r_load_err <= 1'b1;
                end else begin
                    r_q <= load_val;
                end
            end else if (en) begin
                r_q    <= w_step_q;
                r_wrap <= w_step_wrap;
            end
        end
    end

    assign q        = r_q;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule : mod_updown_counter
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_updown_counter
// Description : Self-checking bench for mod_updown_counter. Drives a decimal
//               counter (MODULUS=10, RESET_VAL=3), a full-range counter
//               (MODULUS=16) and a two-stage decimal cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;
    import counter_pkg::*;

    localparam int CW = clog2(10);

    typedef struct {
        int q;
        bit wrap;
        bit err;
    } mstate_t;

    typedef struct {
        string   tag;
        mstate_t st;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    // Decimal counter A
    logic          a_en = 0, a_up = 0, a_clr = 0, a_ld = 0;
    logic [CW-1:0] a_lv = '0;
    logic [CW-1:0] a_q;
    logic          a_tc, a_wrap, a_err;

    // Full-range counter B
    logic          b_en = 0, b_up = 0, b_clr = 0, b_ld = 0;
    logic [3:0]    b_lv = '0;
    logic [3:0]    b_q;
    logic          b_tc, b_wrap, b_err;

    // Cascade
    logic          c_en = 0;
    logic [CW-1:0] c0_q, c1_q;
    logic          c0_tc, c0_wrap, c0_err, c1_tc, c1_wrap, c1_err;

    int      n_checks = 0;
    int      n_errors = 0;
    exp_t    sb[$];
    mstate_t s_a, s_b;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(CW), .MODULUS(10), .RESET_VAL(3)) dut_a (
        .clk(clk), .reset(reset), .en(a_en), .up_dn(a_up), .clear(a_clr),
        .load(a_ld), .load_val(a_lv), .q(a_q), .tc(a_tc), .wrap(a_wrap),
        .load_err(a_err)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_b (
        .clk(clk), .reset(reset), .en(b_en), .up_dn(b_up), .clear(b_clr),
        .load(b_ld), .load_val(b_lv), .q(b_q), .tc(b_tc), .wrap(b_wrap),
        .load_err(b_err)
    );

    mod_updown_counter #(.WIDTH(CW), .MODULUS(10), .RESET_VAL(0)) dut_c0 (
        .clk(clk), .reset(reset), .en(c_en), .up_dn(DIR_UP), .clear(1'b0),
        .load(1'b0), .load_val({CW{1'b0}}), .q(c0_q), .tc(c0_tc),
        .wrap(c0_wrap), .load_err(c0_err)
    );

    mod_updown_counter #(.WIDTH(CW), .MODULUS(10), .RESET_VAL(0)) dut_c1 (
        .clk(clk), .reset(reset), .en(c0_tc), .up_dn(DIR_UP), .clear(1'b0),
        .load(1'b0), .load_val({CW{1'b0}}), .q(c1_q), .tc(c1_tc),
        .wrap(c1_wrap), .load_err(c1_err)
    );

    // Behavioural reference of one clock edge.
    function automatic mstate_t ref_next(input int m, input mstate_t s,
                                         input bit clr, input bit ld,
                                         input bit en, input bit up, input int lv);
        mstate_t r;
        r.q = s.q; r.wrap = 1'b0; r.err = 1'b0;
        if (clr) begin
            r.q = 0;
        end else if (ld) begin
            if (lv >= m) begin r.q = m - 1; r.err = 1'b1; end
            else r.q = lv;
        end else if (en) begin
            if (up) begin
                if (s.q == m - 1) begin r.q = 0; r.wrap = 1'b1; end
                else r.q = s.q + 1;
            end else begin
                if (s.q == 0) begin r.q = m - 1; r.wrap = 1'b1; end
                else r.q = s.q - 1;
            end
        end
        return r;
    endfunction

    function automatic bit ref_tc(input int m, input mstate_t s, input bit clr,
                                  input bit ld, input bit en, input bit up);
        return en && !clr && !ld && (up ? (s.q == m - 1) : (s.q == 0));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        a_en = 0; a_up = 0; a_clr = 0; a_ld = 0; a_lv = '0;
        b_en = 0; b_up = 0; b_clr = 0; b_ld = 0; b_lv = '0;
    endtask

    // One directed step on counter A (sel_b=0) or B (sel_b=1): check tc in
    // the driving cycle, queue the expected post-edge state, then compare.
    task automatic step(input bit sel_b, input bit clr, input bit ld, input bit en,
                        input bit up, input int lv, input string tag);
        mstate_t cur, nxt;
        exp_t    e;
        int      m;
        m   = sel_b ? 16 : 10;
        cur = sel_b ? s_b : s_a;
        @(negedge clk);
        if (sel_b) begin
            b_clr = clr; b_ld = ld; b_en = en; b_up = up; b_lv = 4'(lv);
        end else begin
            a_clr = clr; a_ld = ld; a_en = en; a_up = up; a_lv = CW'(lv);
        end
        #1;
        check({tag, " tc"}, 32'(sel_b ? b_tc : a_tc), 32'(ref_tc(m, cur, clr, ld, en, up)));
        nxt     = ref_next(m, cur, clr, ld, en, up, lv);
        e.tag   = tag;
        e.st    = nxt;
        sb.push_back(e);
        if (sel_b) s_b = nxt; else s_a = nxt;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, " q"},    32'(sel_b ? b_q    : a_q),    32'(e.st.q));
        check({e.tag, " wrap"}, 32'(sel_b ? b_wrap : a_wrap), 32'(e.st.wrap));
        check({e.tag, " err"},  32'(sel_b ? b_err  : a_err),  32'(e.st.err));
        idle_inputs();
    endtask

    initial begin
        int wraps;

        // Asynchronous reset assertion before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst async q", 32'(a_q), 32'd3);
        check("rst async wrap", 32'(a_wrap), 32'd0);
        check("rst async err", 32'(a_err), 32'd0);
        check("rst b q", 32'(b_q), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst hold q", 32'(a_q), 32'd3);
        @(negedge clk);
        reset = 1'b0;
        s_a = '{q: 3, wrap: 1'b0, err: 1'b0};
        s_b = '{q: 0, wrap: 1'b0, err: 1'b0};

        // Up-count through the wrap.
        step(0, 0, 1, 0, 0, 8, "load 8");
        step(0, 0, 0, 1, 1, 0, "up 8->9");
        step(0, 0, 0, 1, 1, 0, "up 9->0");
        step(0, 0, 0, 1, 1, 0, "up 0->1");

        // Down-count through the wrap.
        step(0, 0, 1, 0, 0, 1, "load 1");
        step(0, 0, 0, 1, 0, 0, "dn 1->0");
        step(0, 0, 0, 1, 0, 0, "dn 0->9");
        step(0, 0, 0, 1, 0, 0, "dn 9->8");

        // Direction change, hold, load range and priority.
        step(0, 0, 0, 1, 1, 0, "up 8->9");
        step(0, 0, 0, 0, 1, 0, "hold");
        step(0, 0, 1, 0, 0, 12, "load 12");
        step(0, 1, 1, 1, 1, 12, "clr+ld+en");
        step(0, 0, 1, 1, 0, 0, "load same");
        step(0, 0, 1, 0, 0, 10, "load 10");
        step(0, 0, 1, 0, 0, 9, "load 9");

        // Full-range modulus.
        step(1, 0, 1, 0, 0, 15, "b load 15");
        step(1, 0, 0, 1, 1, 0, "b up 15->0");
        step(1, 0, 0, 1, 0, 0, "b dn 0->15");
        step(1, 0, 0, 1, 0, 0, "b dn 15->14");

        // Reset mid-cycle while a wrap pulse is pending.
        step(0, 0, 0, 1, 1, 0, "up 9->0 pre-rst");
        #2 reset = 1'b1;
        #1;
        check("rst mid q", 32'(a_q), 32'd3);
        check("rst mid wrap", 32'(a_wrap), 32'd0);
        check("rst mid b q", 32'(b_q), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Two-stage decimal cascade counting 0..99 and back to 00.
        @(negedge clk);
        c_en  = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("cascade %0d", i), 32'(int'(c1_q) * 10 + int'(c0_q)), 32'(i % 100));
            check($sformatf("c0 wrap %0d", i), 32'(c0_wrap), 32'((i % 10) == 0));
            if (c1_wrap === 1'b1) wraps++;
        end
        @(negedge clk);
        c_en = 1'b0;
        check("c1 wrap count", 32'(wraps), 32'd1);
        check("cascade err", 32'({c0_err, c1_err}), 32'd0);
        check("cascade tc idle", 32'({c0_tc, c1_tc}), 32'd0);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mod_updown_counter
`default_nettype wire

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous modulo-N up/down counter. It is the successor to the team's fixed 4-bit ripple counter: all bits change on one clock edge, so there is no ripple settling. It adds configurable width and modulus, direction control, count enable, synchronous clear, and parallel load. It also provides a cascade terminal-count output and a wrap pulse, and is intended for timers, address generators and frequency dividers.

## Interface
Parameters:
- WIDTH, 4: counter width in bits, 1..32.
- MODULUS, 16: count range 0..MODULUS-1. Legal range is 2..2**WIDTH; elaboration fails outside it.
- RESET_VAL, 0: value of q after reset. Must be less than MODULUS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count; combinational, for cascading.
- wrap  output  1  registered one-cycle pulse after a wrap.
- load_err  output  1  registered one-cycle pulse after an out-of-range load.

## Operation
- On reset assertion, immediately: q = RESET_VAL, wrap = 0, load_err = 0. All outputs hold these values while reset is high.
- Each rising edge applies exactly one action, in this priority order:
  - **clear:** q <= 0.
  - **load:** q <= load_val, or q <= MODULUS-1 if load_val >= MODULUS. In the out-of-range case load_err <= 1.
  - **en, up:** q <= (q == MODULUS-1) ? 0 : q+1.
  - **en, down:** q <= (q == 0) ? MODULUS-1 : q-1.
  - **otherwise:** hold.
- tc = en & ~clear & ~load & (up_dn ? q == MODULUS-1 : q == 0).
- wrap <= 1 on an edge where the en branch wraps (up MODULUS-1→0 or down 0→MODULUS-1); otherwise 0.
- load_err <= 0 on every edge where no out-of-range load occurs.
- Arithmetic:
  - Compare and increment in WIDTH+1 bits.
  - When MODULUS == 2**WIDTH, wrap equals natural binary overflow. The result is still formed explicitly, not by truncation.
- Direction change: a change of up_dn takes effect at the next edge. There is no extra step or skipped value.
- clear, load and en asserted together: clear wins; no wrap and no load_err.
- load of a value equal to the current q is a legal no-change load.
- Cascade: stage k+1 en = stage k tc. The chain then counts as a single counter of MODULUS**n.

## Timing
- Latency of one cycle from control inputs to q, wrap and load_err.
- tc is combinational from q, en, up_dn, clear and load. It is valid in the same cycle as those inputs.
- reset is asynchronous on assertion. Deassertion must be synchronised externally to clk; the block adds no synchroniser.
- The first count edge is the first rising clk edge after reset deasserts.
- Reset asserted mid-count: q jumps to RESET_VAL without waiting for a clock edge. Any pending wrap or load_err pulse is cancelled.

## Structure
- Shared package counter_pkg:
  - localparam-style constants DIR_UP = 1'b1 and DIR_DN = 1'b0.
  - A function clog2 used by instantiators to size WIDTH from MODULUS.
- One natural sub-module, mod_step: purely combinational. It takes q, up_dn and MODULUS and returns next_q and wrap_next. The top level holds the registers and the priority mux.

## Test plan
- **Reset:** WIDTH=4, MODULUS=10, RESET_VAL=3. Assert reset asynchronously mid-cycle → q=3 immediately, wrap=0, load_err=0.
- **Up-count wrap:** en=1, up_dn=1 from q=8 → q goes 9, 0, 1. wrap=1 only in the cycle after 9→0. tc=1 only while q=9.
- **Down-count wrap:** en=1, up_dn=0 from q=1 → q goes 0, 9, 8. wrap pulses after 0→9. tc=1 only while q=0.
- **Priority and load range:**
  - load=1, load_val=12 (MODULUS=10) → q=9 and load_err pulses.
  - Next cycle: clear=1, load=1 and en=1 together → q=0, no wrap, no load_err.
- **Full-range modulus:** WIDTH=4, MODULUS=16, counting up from 15 → q=0 and wrap pulses. Counting down from 0 → q=15.
- **Cascade:** two MODULUS=10 instances with the second stage's en tied to the first stage's tc. Count 0..99 → the pair reads 99 then 00. The second stage wraps exactly once per 100 enabled cycles.
